// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-master arbiter/sequencer in front of a single-port data memory with a
// combinational read port, a posedge write port and MemRd/MemWr strobes.
// Master 0 is the read-only instruction-fetch port and master 1 is the
// load/store port. Requests are serialised with round-robin fairness. The
// strobes are held for 1+WAIT_CYCLES cycles, and every result comes back
// with a one-cycle rvalid pulse. A misaligned or out-of-range address is
// answered with err=1 and never reaches the memory.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   m0_req_i, m0_addr_i        master 0 read request / byte address
//   m0_ready_o                 master 0 accept pulse
//   m0_rvalid_o, m0_rdata_o,
//   m0_err_o                   master 0 response
//   m1_req_i, m1_we_i,
//   m1_addr_i, m1_wdata_i      master 1 request (we=1 store, we=0 load)
//   m1_ready_o                 master 1 accept pulse
//   m1_rvalid_o, m1_rdata_o,
//   m1_err_o                   master 1 response (rdata=0 for stores)
//   mem_rd_o, mem_wr_o         registered memory strobes
//   mem_addr_o, mem_wdata_o    memory address / write data (0 outside ACCESS)
//   mem_rdata_i                memory read data (combinational)
//   busy_o                     FSM not in IDLE
//
// Handshake: a master raises mX_req_i with its address/data and holds them
// until it sees mX_ready_o high during a cycle; the request is taken at the
// end of that cycle. After that the master may drop req and change
// addr/wdata freely. The response is a single-cycle mX_rvalid_o pulse
// carrying rdata/err, and it cannot be back-pressured.

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_ready_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ready_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);
    localparam logic [3:0]        WAIT_INIT   = 4'(WAIT_CYCLES);

    state_t state_q, state_d;

    // active_q keeps the combinational ready pulses low while in reset and
    // for the first cycle after it, so a master holding req across reset
    // is never told it was accepted while the block is being cleared.
    logic              active_q;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic              req0, req1;
    logic              grant_valid, grant_id;
    logic              sel_we, addr_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration: on a tie the master that did not win last time wins.
    always_comb begin
        req0        = m0_req_i & active_q;
        req1        = m1_req_i & active_q;
        grant_valid = (state_q == S_IDLE) && (req0 || req1);
        grant_id    = (req0 && req1) ? ~last_grant_q : req1;
        sel_addr    = grant_id ? m1_addr_i : m0_addr_i;
        sel_we      = grant_id & m1_we_i;
        sel_wdata   = grant_id ? m1_wdata_i : '0;
        addr_err    = (sel_addr[1:0] != 2'b00) ||
                      ({2'b00, sel_addr[ADDR_W-1:2]} >= MEM_WORDS_A);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = addr_err ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        if (grant_valid) begin
            last_grant_d = grant_id;
            id_d         = grant_id;
            we_d         = sel_we;
            err_d        = addr_err;
            addr_d       = sel_addr;
            wdata_d      = sel_wdata;
            result_d     = '0;
            cnt_d        = WAIT_INIT;
        end else if (state_q == S_ACCESS) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                result_d = we_q ? '0 : mem_rdata_i;
            end
        end
    end

    // The strobes are registered from next-state values. mem_wr is only
    // raised for the ACCESS cycle whose counter is 0, which puts exactly
    // one write edge at the end of the access window.
    always_comb begin
        mem_rd_d = (state_d == S_ACCESS) && !we_d;
        mem_wr_d = (state_d == S_ACCESS) && we_d && (cnt_d == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            active_q     <= 1'b1;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    // Output logic
    always_comb begin
        m0_ready_o  = grant_valid && !grant_id;
        m1_ready_o  = grant_valid && grant_id;
        m0_rvalid_o = (state_q == S_DONE) && !id_q;
        m1_rvalid_o = (state_q == S_DONE) && id_q;
        m0_rdata_o  = m0_rvalid_o ? result_q : '0;
        m1_rdata_o  = m1_rvalid_o ? result_q : '0;
        m0_err_o    = m0_rvalid_o && err_q;
        m1_err_o    = m1_rvalid_o && err_q;
        mem_rd_o    = mem_rd_q;
        mem_wr_o    = mem_wr_q;
        mem_addr_o  = (state_q == S_ACCESS) ? addr_q : '0;
        mem_wdata_o = (state_q == S_ACCESS) ? wdata_q : '0;
        busy_o      = (state_q != S_IDLE);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data memory, which has a combinational read, a write on posedge clk, and MemRd/MemWr strobes.
- Master 0 is the read-only instruction-fetch port; master 1 is the load/store port.
- The block serialises requests with round-robin fairness and drives the memory strobes for a programmable number of cycles.
- It returns each result with a one-cycle valid pulse, and flags misaligned or out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, address width of both masters and the memory port
- DATA_W, 32, data width
- MEM_WORDS, 1024, number of memory words; word index = addr[11:2]
- WAIT_CYCLES, 0, extra cycles the strobes are held before data is sampled (0..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 read request; held until m0_ready
- m0_addr  in  ADDR_W  master 0 byte address
- m0_ready  out  1  one-cycle pulse: master 0 request accepted
- m0_rvalid  out  1  one-cycle pulse: master 0 result valid
- m0_rdata  out  DATA_W  master 0 read data; valid with m0_rvalid
- m0_err  out  1  master 0 error; valid with m0_rvalid
- m1_req  in  1  master 1 request; held until m1_ready
- m1_we  in  1  master 1 write enable (1 = store, 0 = load)
- m1_addr  in  ADDR_W  master 1 byte address
- m1_wdata  in  DATA_W  master 1 store data
- m1_ready  out  1  one-cycle pulse: master 1 request accepted
- m1_rvalid  out  1  one-cycle pulse: master 1 result or write acknowledge
- m1_rdata  out  DATA_W  master 1 load data; 0 for stores
- m1_err  out  1  master 1 error; valid with m1_rvalid
- mem_rd  out  1  memory MemRd
- mem_wr  out  1  memory MemWr
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational)
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - last_grant is set to 1, so master 0 wins the first tie.
  - The wait counter clears.
  - Reset asserted mid-access aborts immediately. No mem_wr is issued after rst_n falls, and no rvalid is ever produced for the aborted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only one master requesting: that master is granted.
  - Both masters requesting: grant goes to the master that is not last_grant.
  - On grant:
    - pulse mX_ready for this cycle;
    - latch id, addr, we (forced 0 for master 0) and wdata;
    - update last_grant;
    - load counter = WAIT_CYCLES.
  - Error check on the latched address: addr[1:0] != 0, or addr[ADDR_W-1:2] >= MEM_WORDS.
    - Error: next state is DONE with err flag set.
    - Otherwise: next state is ACCESS.
  - No request: stay in IDLE with strobes at 0.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latches.
  - mem_rd = !we, held high for every ACCESS cycle.
  - mem_wr = we, asserted only in the cycle where counter == 0, so exactly one write edge occurs.
  - counter != 0: decrement the counter and stay in ACCESS.
  - counter == 0: register mem_rdata (reads) or 0 (writes) into the result, then go to DONE.
- DONE:
  - Pulse mX_rvalid for the latched id, with mX_rdata = result and mX_err = err flag.
  - On error: rdata = 0, and no memory strobe was issued.
  - Next state is IDLE.
- Strobes and idle values:
  - Strobes are registered outputs and are 0 outside ACCESS.
  - mem_addr and mem_wdata are 0 outside ACCESS.
  - rdata outputs of the master that is not being answered stay 0.
- Latency:
  - Accept at cycle T; ACCESS during T+1 .. T+1+WAIT_CYCLES; rvalid at T+2+WAIT_CYCLES.
  - Error path: rvalid at T+1.
  - Minimum spacing between accepts is 3+WAIT_CYCLES cycles.
- Requests that arrive while busy are not accepted. mX_ready stays 0, and the master holds req.
- A master may drop req only after its ready pulse. Changing addr or wdata after ready has no effect.

Test Plan:
- Master 0 reads 0x00000010 with mem word 4 = 0xDEADBEEF, WAIT_CYCLES=0 → m0_ready at T, mem_rd=1 at T+1, m0_rvalid=1 and m0_rdata=0xDEADBEEF at T+2, m0_err=0.
- Master 1 stores 0x12345678 to 0x20, then loads 0x20, WAIT_CYCLES=2 → mem_wr high for exactly 1 cycle (the 3rd ACCESS cycle), m1_rvalid at T+4 with rdata=0; the load returns 0x12345678.
- Both masters request continuously from reset → grants alternate m0, m1, m0, m1; each rvalid goes to the correct master; one accept every 3 cycles.
- Master 1 load at 0x00000006 (misaligned), and at 0x00001000 (index 1024 ≥ MEM_WORDS) → m1_rvalid at T+1, m1_err=1, m1_rdata=0, mem_rd and mem_wr never asserted.
- Master 1 store accepted, rst_n pulled low during ACCESS with WAIT_CYCLES=3 → all outputs 0 asynchronously, mem word unchanged, no m1_rvalid; after release, master 0 wins the first tie.
